blob_centroid: RTL and testbench

- Downstream consumer of the erosion stage in the NTSC tracking pipeline.
- Takes the binary mask (0x00/0xFF) with its raster counters, accumulates pixel count and x/y coordinate sums over the active frame, then divides once per frame in vblank.
- Publishes the blob centroid to the overlay/servo logic.

---
 rtl/blob_pkg.sv | 17 +
 rtl/seq_divider.sv | 73 +++++++
 rtl/blob_centroid.sv | 231 +++++++++++++++++++++++
 tb/tb_blob_centroid.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared defaults and FSM state type for the blob centroid stage.
// Optional bounding-box tracking is enabled with BLOB_CENTROID_BBOX_EN.
package blob_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int SUM_W_DEF    = 32;
    localparam int CNT_W_DEF    = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } blob_state_t;

endpackage

// File: rtl/seq_divider.sv
// Start/busy/done restoring divider; the start cycle performs the first step,
// so a quotient is ready DVD_W cycles after start with done pulsing in the last.
module seq_divider #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
);

    localparam int CW = $clog2(DVD_W);

    logic [DVS_W-1:0] rem_reg;
    logic [DVD_W-1:0] q_reg;
    logic [DVS_W-1:0] dvs_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    // Shift one dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [DVS_W+DVD_W-1:0] div_step(
        input logic [DVS_W-1:0] rem,
        input logic [DVD_W-1:0] q,
        input logic [DVS_W-1:0] d
    );
        logic [DVS_W:0] trial;
        trial = {rem, q[DVD_W-1]};
        if (trial >= {1'b0, d}) begin
            trial = trial - {1'b0, d};
            return {trial[DVS_W-1:0], q[DVD_W-2:0], 1'b1};
        end
        return {trial[DVS_W-1:0], q[DVD_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg  <= '0;
            q_reg    <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start && !busy_reg) begin
                {rem_reg, q_reg} <= div_step('0, dividend, divisor);
                dvs_reg          <= divisor;
                cnt_reg          <= CW'(DVD_W - 1);
                busy_reg         <= 1'b1;
            end else if (busy_reg) begin
                {rem_reg, q_reg} <= div_step(rem_reg, q_reg, dvs_reg);
                cnt_reg          <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = q_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/blob_centroid.sv
// Accumulates mask hits per frame and divides once in vblank to publish the centroid.
// Define BLOB_CENTROID_BBOX_EN to also publish the hit bounding box.
module blob_centroid
    import blob_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic [7:0]       color,
    output logic [10:0]      centroid_x,
    output logic [9:0]       centroid_y,
    output logic [CNT_W-1:0] pixel_count,
    output logic             found,
    output logic             valid,
    output logic [10:0]      bbox_xmin,
    output logic [10:0]      bbox_xmax,
    output logic [9:0]       bbox_ymin,
    output logic [9:0]       bbox_ymax
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    logic [10:0] hcount_s1;
    logic [9:0]  vcount_s1;
    logic [7:0]  color_s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_s1 <= '0;
            vcount_s1 <= '0;
            color_s1  <= '0;
        end else begin
            hcount_s1 <= hcount;
            vcount_s1 <= vcount;
            color_s1  <= color;
        end
    end

    logic hit;
    logic frame_start;
    logic frame_end;

    assign hit         = (color_s1 != 8'd0) && (hcount_s1 < H_LIM) && (vcount_s1 < V_LIM);
    assign frame_start = (hcount_s1 == 11'd0) && (vcount_s1 == 10'd0);
    assign frame_end   = (hcount_s1 == 11'd0) && (vcount_s1 == V_LIM);

    logic [SUM_W-1:0] sum_x_reg;
    logic [SUM_W-1:0] sum_y_reg;
    logic [CNT_W-1:0] count_reg;
    logic [SUM_W-1:0] hx;
    logic [SUM_W-1:0] vy;

    assign hx = SUM_W'(hcount_s1);
    assign vy = SUM_W'(vcount_s1);

    // Frame start clears and counts pixel (0,0) in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_x_reg <= '0;
            sum_y_reg <= '0;
            count_reg <= '0;
        end else if (frame_start) begin
            sum_x_reg <= hit ? hx : '0;
            sum_y_reg <= hit ? vy : '0;
            count_reg <= hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            sum_x_reg <= sum_x_reg + hx;
            sum_y_reg <= sum_y_reg + vy;
            if (count_reg != '1) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    blob_state_t      state_reg;
    logic [SUM_W-1:0] snap_sum_y;
    logic [CNT_W-1:0] snap_cnt;
    logic [10:0]      qx_reg;
    logic [9:0]       qy_reg;

    logic             div_start;
    logic [SUM_W-1:0] div_dividend;
    logic [CNT_W-1:0] div_divisor;
    logic             div_busy;
    logic             div_done;
    logic [SUM_W-1:0] div_quotient;
    logic [CNT_W-1:0] div_rem_unused;

    // The X divide is launched straight from the live sums on the frame-end cycle,
    // which hold their final values then; Y uses the snapshot.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = snap_sum_y;
        div_divisor  = snap_cnt;
        if (state_reg == IDLE && frame_end && count_reg != '0) begin
            div_start    = 1'b1;
            div_dividend = sum_x_reg;
            div_divisor  = count_reg;
        end else if (state_reg == DIV_X && div_done) begin
            div_start = 1'b1;
        end
    end

    seq_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_rem_unused)
    );

    logic unused_div;
    assign unused_div = ^{div_quotient[SUM_W-1:11], div_busy, div_rem_unused};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            snap_sum_y  <= '0;
            snap_cnt    <= '0;
            qx_reg      <= '0;
            qy_reg      <= '0;
            centroid_x  <= '0;
            centroid_y  <= '0;
            pixel_count <= '0;
            found       <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_end) begin
                        snap_sum_y <= sum_y_reg;
                        snap_cnt   <= count_reg;
                        state_reg  <= (count_reg == '0) ? PUBLISH : DIV_X;
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        qx_reg    <= div_quotient[10:0];
                        state_reg <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        qy_reg    <= div_quotient[9:0];
                        state_reg <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    valid       <= 1'b1;
                    pixel_count <= snap_cnt;
                    found       <= (snap_cnt != '0);
                    centroid_x  <= (snap_cnt != '0) ? qx_reg : '0;
                    centroid_y  <= (snap_cnt != '0) ? qy_reg : '0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef BLOB_CENTROID_BBOX_EN
    logic [10:0] xmin_reg, xmax_reg, snap_xmin, snap_xmax;
    logic [9:0]  ymin_reg, ymax_reg, snap_ymin, snap_ymax;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xmin_reg <= '1;
            xmax_reg <= '0;
            ymin_reg <= '1;
            ymax_reg <= '0;
        end else if (frame_start) begin
            xmin_reg <= hit ? hcount_s1 : '1;
            xmax_reg <= hit ? hcount_s1 : '0;
            ymin_reg <= hit ? vcount_s1 : '1;
            ymax_reg <= hit ? vcount_s1 : '0;
        end else if (hit) begin
            if (hcount_s1 < xmin_reg) xmin_reg <= hcount_s1;
            if (hcount_s1 > xmax_reg) xmax_reg <= hcount_s1;
            if (vcount_s1 < ymin_reg) ymin_reg <= vcount_s1;
            if (vcount_s1 > ymax_reg) ymax_reg <= vcount_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_xmin <= '0;
            snap_xmax <= '0;
            snap_ymin <= '0;
            snap_ymax <= '0;
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
        end else begin
            if (state_reg == IDLE && frame_end) begin
                snap_xmin <= xmin_reg;
                snap_xmax <= xmax_reg;
                snap_ymin <= ymin_reg;
                snap_ymax <= ymax_reg;
            end
            if (state_reg == PUBLISH) begin
                bbox_xmin <= (snap_cnt != '0) ? snap_xmin : '0;
                bbox_xmax <= (snap_cnt != '0) ? snap_xmax : '0;
                bbox_ymin <= (snap_cnt != '0) ? snap_ymin : '0;
                bbox_ymax <= (snap_cnt != '0) ? snap_ymax : '0;
            end
        end
    end
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_blob_centroid.sv
// Self-checking bench for blob_centroid: directed frame table, corner sequences
// and random frames against a plain-arithmetic model (bbox checks follow BLOB_CENTROID_BBOX_EN).
module tb_blob_centroid;

    localparam int HA  = 1024;
    localparam int VA  = 768;
    localparam int LAT = 67;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  color;
    logic [10:0] centroid_x;
    logic [9:0]  centroid_y;
    logic [19:0] pixel_count;
    logic        found;
    logic        valid;
    logic [10:0] bbox_xmin, bbox_xmax;
    logic [9:0]  bbox_ymin, bbox_ymax;

    always #5 clk = ~clk;

    blob_centroid dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .color       (color),
        .centroid_x  (centroid_x),
        .centroid_y  (centroid_y),
        .pixel_count (pixel_count),
        .found       (found),
        .valid       (valid),
        .bbox_xmin   (bbox_xmin),
        .bbox_xmax   (bbox_xmax),
        .bbox_ymin   (bbox_ymin),
        .bbox_ymax   (bbox_ymax)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int h;
        int v;
        int c;
    } pix_t;
    pix_t pix_q[$];

    typedef struct {
        string name;
        int x0, y0, w, h;
        int px, py;
        bit use_p;
        int c00;
        bit oow;
        int ecx, ecy, ecnt, efound;
        int exmin, exmax, eymin, eymax;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] cap_cx, cap_cy, cap_cnt, cap_found, cap_xmin, cap_xmax, cap_ymin, cap_ymax;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input int c);
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        color  = 8'(c);
    endtask

    task automatic send_frame(input int c00);
        drive(0, 0, c00);
        foreach (pix_q[i]) drive(pix_q[i].h, pix_q[i].v, pix_q[i].c);
        drive(5, 0, 0);
        drive(5, 0, 0);
        drive(0, VA, 0);
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            drive(5, 0, 0);
            if (valid === 1'b1) begin
                lat       = i;
                cap_cx    = 32'(centroid_x);
                cap_cy    = 32'(centroid_y);
                cap_cnt   = 32'(pixel_count);
                cap_found = 32'(found);
                cap_xmin  = 32'(bbox_xmin);
                cap_xmax  = 32'(bbox_xmax);
                cap_ymin  = 32'(bbox_ymin);
                cap_ymax  = 32'(bbox_ymax);
                break;
            end
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no valid, expected valid within 200 cycles", name);
        end
        drive(5, 0, 0);
        check({name, "_pulse"}, 32'(valid), 32'd0);
    endtask

    task automatic check_result(input string name, input int lat, input int ecx, input int ecy,
                                input int ecnt, input int efound, input int exmin, input int exmax,
                                input int eymin, input int eymax);
        $display("[TB] %s: lat=%0d cnt=%0d cx=%0d cy=%0d found=%0d bbox=%0d/%0d/%0d/%0d",
                 name, lat, cap_cnt, cap_cx, cap_cy, cap_found, cap_xmin, cap_xmax, cap_ymin, cap_ymax);
        if (ecnt > 0) check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_cx"}, cap_cx, 32'(ecx));
        check({name, "_cy"}, cap_cy, 32'(ecy));
        check({name, "_count"}, cap_cnt, 32'(ecnt));
        check({name, "_found"}, cap_found, 32'(efound));
`ifdef BLOB_CENTROID_BBOX_EN
        check({name, "_xmin"}, cap_xmin, 32'(exmin));
        check({name, "_xmax"}, cap_xmax, 32'(exmax));
        check({name, "_ymin"}, cap_ymin, 32'(eymin));
        check({name, "_ymax"}, cap_ymax, 32'(eymax));
`else
        check({name, "_bbox"}, cap_xmin | cap_xmax | cap_ymin | cap_ymax, 32'd0);
        if (exmin < 0 && exmax < 0 && eymin < 0 && eymax < 0) $display("[TB] unexpected bbox args");
`endif
    endtask

    initial begin
        int lat;
        bit saw_valid;

        vecs[0] = '{"single", 0, 0, 0, 0, 100, 50, 1, 0, 0, 100, 50, 1, 1, 100, 100, 50, 50};
        vecs[1] = '{"square", 200, 300, 10, 10, 0, 0, 0, 0, 0, 204, 304, 100, 1, 200, 209, 300, 309};
        vecs[2] = '{"origin", 0, 0, 0, 0, 3, 1, 1, 255, 0, 1, 0, 2, 1, 0, 3, 0, 1};
        vecs[3] = '{"empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{"window", 0, 0, 0, 0, 10, 20, 1, 0, 1, 10, 20, 1, 1, 10, 10, 20, 20};
        vecs[5] = '{"corner", 0, 0, 0, 0, 1023, 767, 1, 0, 1, 1023, 767, 1, 1, 1023, 1023, 767, 767};

        reset_n = 1'b0;
        hcount  = 11'd5;
        vcount  = 10'd0;
        color   = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_cx", 32'(centroid_x), 32'd0);
        check("reset_cy", 32'(centroid_y), 32'd0);
        check("reset_count", 32'(pixel_count), 32'd0);
        check("reset_found_valid", {30'd0, found, valid}, 32'd0);
        check("reset_bbox", 32'(bbox_xmin | bbox_xmax) | 32'(bbox_ymin | bbox_ymax), 32'd0);
        reset_n = 1'b1;
        repeat (2) drive(5, 0, 0);

        for (int t = 0; t < 6; t++) begin
            pix_q.delete();
            for (int y = 0; y < vecs[t].h; y++)
                for (int x = 0; x < vecs[t].w; x++)
                    pix_q.push_back('{vecs[t].x0 + x, vecs[t].y0 + y, 255});
            if (vecs[t].oow) begin
                pix_q.push_back('{1030, 770, 255});
                pix_q.push_back('{1024, 100, 255});
                pix_q.push_back('{100, 768, 255});
            end
            if (vecs[t].use_p) pix_q.push_back('{vecs[t].px, vecs[t].py, 255});
            send_frame(vecs[t].c00);
            wait_valid(vecs[t].name, lat);
            check_result(vecs[t].name, lat, vecs[t].ecx, vecs[t].ecy, vecs[t].ecnt, vecs[t].efound,
                         vecs[t].exmin, vecs[t].exmax, vecs[t].eymin, vecs[t].eymax);
        end

        // Second frame end while dividing is dropped; first result survives.
        pix_q.delete();
        pix_q.push_back('{100, 50, 255});
        send_frame(0);
        repeat (10) drive(5, 0, 0);
        drive(0, 0, 255);
        drive(700, 700, 255);
        drive(5, 0, 0);
        drive(0, VA, 0);
        wait_valid("busy", lat);
        check("busy_cx", cap_cx, 32'd100);
        check("busy_cy", cap_cy, 32'd50);
        check("busy_count", cap_cnt, 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive(5, 0, 0);
            if (valid === 1'b1) saw_valid = 1'b1;
        end
        check("busy_dropped", 32'(saw_valid), 32'd0);
        $display("[TB] busy: first result cx=%0d cy=%0d, extra valid=%0d", cap_cx, cap_cy, saw_valid);

        // Reset 10 cycles into DIV_X aborts the divide.
        pix_q.delete();
        pix_q.push_back('{300, 400, 255});
        send_frame(0);
        repeat (10) drive(5, 0, 0);
        reset_n = 1'b0;
        #1;
        check("midreset_cx", 32'(centroid_x), 32'd0);
        check("midreset_cy", 32'(centroid_y), 32'd0);
        check("midreset_count_found", 32'(pixel_count) | 32'(found), 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(5, 0, 0);
            if (valid !== 1'b0) saw_valid = 1'b1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            drive(5, 0, 0);
            if (valid !== 1'b0) saw_valid = 1'b1;
        end
        check("midreset_novalid", 32'(saw_valid), 32'd0);
        $display("[TB] midreset: outputs cleared, stray valid=%0d", saw_valid);
        pix_q.delete();
        pix_q.push_back('{5, 5, 255});
        send_frame(0);
        wait_valid("after_reset", lat);
        check_result("after_reset", lat, 5, 5, 1, 1, 5, 5, 5, 5);

        for (int r = 0; r < 20; r++) begin
            int c00, n, cnt, sx, sy, xmin, xmax, ymin, ymax, h, v, c;
            string nm;
            pix_q.delete();
            c00 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
            n = (r == 7) ? 0 : int'($urandom_range(1, 30));
            for (int i = 0; i < n; i++) begin
                h = int'($urandom_range(0, 1100));
                v = int'($urandom_range(0, 800));
                if (h == 0) h = 1;
                c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
                pix_q.push_back('{h, v, c});
            end
            cnt = 0; sx = 0; sy = 0;
            xmin = 1 << 30; xmax = -1; ymin = 1 << 30; ymax = -1;
            if (c00 != 0) begin
                cnt = 1; xmin = 0; xmax = 0; ymin = 0; ymax = 0;
            end
            foreach (pix_q[i]) begin
                if (pix_q[i].c != 0 && pix_q[i].h < HA && pix_q[i].v < VA) begin
                    cnt++;
                    sx += pix_q[i].h;
                    sy += pix_q[i].v;
                    if (pix_q[i].h < xmin) xmin = pix_q[i].h;
                    if (pix_q[i].h > xmax) xmax = pix_q[i].h;
                    if (pix_q[i].v < ymin) ymin = pix_q[i].v;
                    if (pix_q[i].v > ymax) ymax = pix_q[i].v;
                end
            end
            nm = $sformatf("rand%0d", r);
            send_frame(c00);
            wait_valid(nm, lat);
            if (cnt > 0)
                check_result(nm, lat, sx / cnt, sy / cnt, cnt, 1, xmin, xmax, ymin, ymax);
            else
                check_result(nm, lat, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
